exe_mem_pipe_buf: RTL and testbench
===================================

# exe_mem_pipe_buf

Parametrised EXE→MEM pipeline stage buffer, the handshaked successor of the fixed single-entry stage register. It holds up to DEPTH in-flight instructions (control bits, ALU result, store data, destination register) in a circular buffer. It supports valid/ready flow control, freeze, and flush, and presents a zero-control bubble to the MEM stage whenever it has nothing valid to issue.

## Interface
Parameters:
- CTRL_W, 3: control field width (bit0 WB_EN, bit1 MEM_R_EN, bit2 MEM_W_EN).
- DATA_W, 32: width of ALU result and of store value (valRm).
- DEST_W, 4: destination register index width.
- DEPTH, 2: number of entries, ≥1; CNT_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  hazard stall; blocks push and pop while high.
- flush  in  1  synchronous discard of all entries (branch taken).
- in_valid  in  1  EXE offers an entry.
- in_ready  out  1  buffer accepts this cycle.
- in_ctrl  in  CTRL_W  control bits.
- in_alu  in  DATA_W  ALU result.
- in_valrm  in  DATA_W  store data.
- in_dest  in  DEST_W  destination register.
- out_valid  out  1  head entry presented.
- out_ready  in  1  MEM consumes head.
- out_ctrl  out  CTRL_W  head control, forced 0 when out_valid=0.
- out_alu  out  DATA_W  head ALU result, 0 when buffer empty.
- out_valrm  out  DATA_W  head store data, 0 when buffer empty.
- out_dest  out  DEST_W  head destination, 0 when buffer empty.
- count  out  CNT_W  current occupancy.

## Operation
- Storage: DEPTH-entry array, rd_ptr/wr_ptr wrap modulo DEPTH (non-power-of-2 DEPTH wraps explicitly at DEPTH-1 → 0), count register.
- in_ready = ~freeze & (count != DEPTH). No pass-through when full.
- out_valid = ~freeze & (count != 0).
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Push writes the entry at wr_ptr and advances wr_ptr. Pop advances rd_ptr.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Outputs are driven combinationally from the head entry (registered storage, no input→output combinational path).
- out_ctrl masked to all-zero whenever out_valid=0, including under freeze, so MEM sees a bubble (no WB, no memory access).
- Data outputs are 0 when count=0. Under freeze with count≠0 they show the held head.
- flush: at the next edge, count, rd_ptr and wr_ptr return to 0.
  - flush overrides a simultaneous push/pop; the offered entry is dropped.
  - flush acts regardless of freeze.
- Entry contents are not cleared by flush and are unobservable afterwards.
- in_valid while in_ready=0: nothing is stored. The producer must hold the entry.

## Timing
- Reset (async assert, sync release by the system): count=0, pointers=0, storage=0.
  - Resulting outputs: out_valid=0, out_ctrl=0, out_alu=0, out_valrm=0, out_dest=0, count=0, in_ready=~freeze.
- Latency: an entry pushed at edge k is visible on out_* with out_valid=1 after edge k (one cycle), if it is the head and freeze=0.
- Throughput: one push and one pop per cycle sustained when 0<count<DEPTH.
- Full (count=DEPTH): in_ready=0 even if out_ready=1 the same cycle. The pop frees a slot for the next cycle.
- Empty: simultaneous in_valid & out_ready → push only; out_valid rises next cycle.
- Freeze mid-stream: state frozen exactly; on deassert, output resumes from the same head with no loss or duplication.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous), without waiting for a clock edge.

## Test plan
- Reset with DEPTH=2: rst=1 mid-cycle → out_valid=0, out_ctrl=3'b000, count=0 immediately; in_ready=1 once rst=0, freeze=0.
- Push ctrl=3'b101, alu=32'h0000_00A5, dest=4'd7 with out_ready=0 → next cycle out_valid=1, out_alu=32'hA5, out_dest=7, count=1.
- Fill to full (2 entries), then out_ready=1 with in_valid=1 → in_ready=0 that cycle, count goes 2→1; the following cycle, push and pop together keep count=1, in FIFO order.
- freeze=1 with count=1 → out_valid=0, out_ctrl=0, out_alu still shows the head value, in_ready=0; after 3 cycles freeze=0 → same head reappears exactly once.
- flush=1 with count=2 plus simultaneous push → next cycle count=0, out_valid=0, and the pushed entry is never seen.
- DEPTH=3 wrap: push 5 sequential values 1..5 with interleaved pops → output order 1,2,3,4,5 with no gaps; count never exceeds 3.

Source files
------------

// File: rtl/exe_mem_pipe_buf.sv
// EXE->MEM pipeline stage buffer: DEPTH-entry circular queue with valid/ready
// handshakes, freeze and flush. A zero-control bubble is presented whenever nothing is issued.
module exe_mem_pipe_buf #(
   parameter  int CTRL_W = 3,
   parameter  int DATA_W = 32,
   parameter  int DEST_W = 4,
   parameter  int DEPTH  = 2,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_valrm,
   input  logic [DEST_W-1:0] in_dest,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_valrm,
   output logic [DEST_W-1:0] out_dest,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CTRL_W-1:0] ctrl_mem  [DEPTH];
   logic [DATA_W-1:0] alu_mem   [DEPTH];
   logic [DATA_W-1:0] valrm_mem [DEPTH];
   logic [DEST_W-1:0] dest_mem  [DEPTH];

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             not_empty;
   logic             not_full;
   logic             push;
   logic             pop;

   // Explicit wrap so non-power-of-two depths stay inside the array.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign not_empty = (count != '0);
   assign not_full  = (count != CNT_W'(DEPTH));
   assign in_ready  = ~freeze & not_full;
   assign out_valid = ~freeze & not_empty;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ctrl_mem[i]  <= '0;
            alu_mem[i]   <= '0;
            valrm_mem[i] <= '0;
            dest_mem[i]  <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            ctrl_mem[wr_ptr]  <= in_ctrl;
            alu_mem[wr_ptr]   <= in_alu;
            valrm_mem[wr_ptr] <= in_valrm;
            dest_mem[wr_ptr]  <= in_dest;
            wr_ptr            <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Control is masked on out_valid (bubble under freeze); data only on emptiness.
   assign out_ctrl  = out_valid ? ctrl_mem[rd_ptr]  : '0;
   assign out_alu   = not_empty ? alu_mem[rd_ptr]   : '0;
   assign out_valrm = not_empty ? valrm_mem[rd_ptr] : '0;
   assign out_dest  = not_empty ? dest_mem[rd_ptr]  : '0;

endmodule

// File: tb/tb_exe_mem_pipe_buf.sv
// Scoreboard bench for exe_mem_pipe_buf: DEPTH=2 and DEPTH=3 instances share one
// directed stimulus stream; per-instance occupancy models and expected queues check every cycle.
module tb_exe_mem_pipe_buf;

   typedef struct packed {
      logic [2:0]  ctrl;
      logic [31:0] alu;
      logic [31:0] valrm;
      logic [3:0]  dest;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        flush;
   logic        in_valid;
   logic [2:0]  in_ctrl;
   logic [31:0] in_alu;
   logic [31:0] in_valrm;
   logic [3:0]  in_dest;
   logic        out_ready;

   logic        ir_w  [2];
   logic        ov_w  [2];
   logic [2:0]  oc_w  [2];
   logic [31:0] oa_w  [2];
   logic [31:0] ovr_w [2];
   logic [3:0]  od_w  [2];
   logic [1:0]  cnt_w [2];

   ent_t        q [2][$];
   int          mcnt [2];
   int          maxc [2];
   bit          acc  [2];
   bit          rec;
   int          order [$];
   int          n_pass;
   int          n_total;

   always #5 clk = ~clk;

   exe_mem_pipe_buf #(.CTRL_W(3), .DATA_W(32), .DEST_W(4), .DEPTH(2)) u_d2 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_ready(ir_w[0]), .in_ctrl(in_ctrl), .in_alu(in_alu),
      .in_valrm(in_valrm), .in_dest(in_dest), .out_valid(ov_w[0]), .out_ready(out_ready),
      .out_ctrl(oc_w[0]), .out_alu(oa_w[0]), .out_valrm(ovr_w[0]), .out_dest(od_w[0]),
      .count(cnt_w[0])
   );

   exe_mem_pipe_buf #(.CTRL_W(3), .DATA_W(32), .DEST_W(4), .DEPTH(3)) u_d3 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_ready(ir_w[1]), .in_ctrl(in_ctrl), .in_alu(in_alu),
      .in_valrm(in_valrm), .in_dest(in_dest), .out_valid(ov_w[1]), .out_ready(out_ready),
      .out_ctrl(oc_w[1]), .out_alu(oa_w[1]), .out_valrm(ovr_w[1]), .out_dest(od_w[1]),
      .count(cnt_w[1])
   );

   task automatic chk(input string nm, input int inst, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[d%0d] t=%0t: got %0h expected %0h", nm, inst + 2, $time, act, exp);
   endtask

   // Monitor: compares every cycle, then advances the models to the coming edge.
   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            q[i].delete();
            mcnt[i] = 0;
            acc[i]  = 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            int   d;
            bit   eir;
            bit   eov;
            ent_t e;
            d   = i + 2;
            eir = !freeze && (mcnt[i] != d);
            eov = !freeze && (mcnt[i] != 0);
            e   = (mcnt[i] != 0) ? q[i][0] : '0;
            chk("count", i, 32'(cnt_w[i]), 32'(mcnt[i]));
            chk("in_ready", i, 32'(ir_w[i]), 32'(eir));
            chk("out_valid", i, 32'(ov_w[i]), 32'(eov));
            chk("out_ctrl", i, 32'(oc_w[i]), eov ? 32'(e.ctrl) : 32'd0);
            chk("out_alu", i, oa_w[i], e.alu);
            chk("out_valrm", i, ovr_w[i], e.valrm);
            chk("out_dest", i, 32'(od_w[i]), 32'(e.dest));
            acc[i] = 1'b0;
            if (flush) begin
               q[i].delete();
               mcnt[i] = 0;
            end else begin
               if (eov && out_ready) begin
                  void'(q[i].pop_front());
                  mcnt[i]--;
                  if (i == 1 && rec) order.push_back(int'(e.alu));
               end
               if (in_valid && eir) begin
                  q[i].push_back({in_ctrl, in_alu, in_valrm, in_dest});
                  mcnt[i]++;
                  acc[i] = 1'b1;
               end
            end
            if (mcnt[i] > maxc[i]) maxc[i] = mcnt[i];
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [2:0] c, input logic [31:0] a,
                        input logic [3:0] d);
      in_valid = v;
      in_ctrl  = c;
      in_alu   = a;
      in_valrm = ~a;
      in_dest  = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      n_pass = 0; n_total = 0; rec = 1'b0;
      maxc[0] = 0; maxc[1] = 0;
      rst = 1'b1; freeze = 1'b0; flush = 1'b0; out_ready = 1'b0;
      offer(1'b0, 3'b000, 32'h0, 4'h0);
      repeat (2) cyc();
      rst = 1'b0;
      cyc();

      // Asynchronous reset in the middle of a cycle with both buffers loaded
      offer(1'b1, 3'b011, 32'h11, 4'd1);
      repeat (2) cyc();
      offer(1'b0, 3'b000, 32'h0, 4'h0);
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("async_rst_valid", i, 32'(ov_w[i]), 32'd0);
         chk("async_rst_ctrl", i, 32'(oc_w[i]), 32'd0);
         chk("async_rst_count", i, 32'(cnt_w[i]), 32'd0);
         chk("async_rst_alu", i, oa_w[i], 32'd0);
      end
      @(posedge clk); #1 rst = 1'b0;
      cyc();

      // Single push, one-cycle latency
      offer(1'b1, 3'b101, 32'h0000_00A5, 4'd7);
      cyc();
      offer(1'b0, 3'b000, 32'h0, 4'h0);
      chk("lat_alu", 0, oa_w[0], 32'hA5);
      chk("lat_dest", 0, 32'(od_w[0]), 32'd7);

      // Fill DEPTH=2, then pop while offering: no pass-through when full
      offer(1'b1, 3'b001, 32'hB0, 4'd2);
      cyc();
      offer(1'b1, 3'b100, 32'hC0, 4'd3);
      out_ready = 1'b1;
      cyc();
      cyc();
      offer(1'b0, 3'b000, 32'h0, 4'h0);
      repeat (4) cyc();

      // Freeze with one entry: bubble on control, head held, then seen exactly once
      out_ready = 1'b0;
      offer(1'b1, 3'b111, 32'hD0, 4'd5);
      cyc();
      offer(1'b1, 3'b011, 32'hE0, 4'd6);
      freeze = 1'b1; out_ready = 1'b1;
      repeat (3) cyc();
      offer(1'b0, 3'b000, 32'h0, 4'h0);
      freeze = 1'b0;
      cyc();
      out_ready = 1'b0;
      cyc();

      // Flush with a simultaneous push
      offer(1'b1, 3'b001, 32'hF1, 4'd8);
      cyc();
      offer(1'b1, 3'b001, 32'hF2, 4'd9);
      cyc();
      offer(1'b1, 3'b111, 32'hF3, 4'd10);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      offer(1'b0, 3'b000, 32'h0, 4'h0);
      chk("flush_count", 0, 32'(cnt_w[0]), 32'd0);
      chk("flush_count", 1, 32'(cnt_w[1]), 32'd0);
      cyc();

      // Wrap on DEPTH=3: values 1..5, producer holds each until accepted
      rec = 1'b1;
      idx = 1;
      for (int n = 0; n < 60 && order.size() < 5; n++) begin
         logic [31:0] nv;
         nv = n;
         if (idx <= 5) offer(1'b1, 3'b001, 32'(idx), 4'(idx));
         else          offer(1'b0, 3'b000, 32'h0, 4'h0);
         out_ready = (idx > 5) ? 1'b1 : ((n >= 3) ? nv[0] : 1'b0);
         cyc();
         if (acc[1]) idx++;
      end
      rec = 1'b0;
      offer(1'b0, 3'b000, 32'h0, 4'h0);
      out_ready = 1'b1;
      chk("wrap_pops", 1, 32'(order.size()), 32'd5);
      for (int i = 0; i < order.size() && i < 5; i++)
         chk("wrap_order", 1, 32'(order[i]), 32'(i + 1));
      chk("max_count", 0, 32'(maxc[0] <= 2), 32'd1);
      chk("max_count", 1, 32'(maxc[1] <= 3), 32'd1);
      chk("wrap_reached_full", 1, 32'(maxc[1]), 32'd3);
      repeat (5) cyc();
      chk("drained", 1, 32'(cnt_w[1]), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
